// File: rtl/uart_resp_tx_if.sv
// Handshake and serial-line bundle between the channel-dump state machine
// and the UART response transmitter.
interface uart_resp_tx_if;
  logic       start_tx;
  logic [7:0] tx_data;
  logic       tx_rdy;
  logic       busy;
  logic       tx_done;
  logic       TX;

  modport master (
    output start_tx, tx_data,
    input  tx_rdy, busy, tx_done, TX
  );

  modport slave (
    input  start_tx, tx_data,
    output tx_rdy, busy, tx_done, TX
  );
endinterface

// File: rtl/uart_resp_tx.sv
// 8N1 UART transmitter, LSB first, with a one-deep holding register so the
// dump state machine can queue the next byte while the current frame shifts.
module uart_resp_tx #(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic           clk,
  input  logic           rst,
  uart_resp_tx_if.slave  bus
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [BW-1:0] baud_cnt_r, baud_cnt_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    hold_r, hold_s;
  logic          hold_vld_r, hold_vld_s;
  logic          tx_r, tx_s;
  logic          tx_done_r, tx_done_s;
  logic          accept_s;
  logic          bit_end_s;

  assign accept_s  = bus.start_tx & ~hold_vld_r;
  assign bit_end_s = (baud_cnt_r == BAUD_LAST);

  // Next-state, datapath and registered-output values for every state register.
  always_comb begin
    state_s    = state_r;
    baud_cnt_s = baud_cnt_r + BAUD_ONE;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    hold_s     = hold_r;
    hold_vld_s = hold_vld_r;
    tx_done_s  = 1'b0;
    tx_s       = 1'b1;

    if (accept_s && (state_r != IDLE)) begin
      hold_s     = bus.tx_data;
      hold_vld_s = 1'b1;
    end else begin
      hold_s     = hold_r;
    end

    case (state_r)
      IDLE: begin
        baud_cnt_s = BAUD_ZERO;
        // A byte left in hold by a concurrent stop-bit-end accept is sent first.
        if (hold_vld_r) begin
          shift_s    = hold_r;
          hold_vld_s = 1'b0;
          state_s    = START;
        end else if (accept_s) begin
          shift_s = bus.tx_data;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          bit_cnt_s  = 3'd0;
          state_s    = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          shift_s    = {1'b0, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_cnt_s = BAUD_ZERO;
          tx_done_s  = 1'b1;
          if (hold_vld_r) begin
            shift_s    = hold_r;
            hold_vld_s = 1'b0;
            state_s    = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        baud_cnt_s = BAUD_ZERO;
        state_s    = IDLE;
      end
    endcase

    // TX is computed from the next state so the line changes on the entry edge.
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      hold_r     <= 8'd0;
      hold_vld_r <= 1'b0;
      tx_r       <= 1'b1;
      tx_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      hold_r     <= hold_s;
      hold_vld_r <= hold_vld_s;
      tx_r       <= tx_s;
      tx_done_r  <= tx_done_s;
    end
  end

  assign bus.TX      = tx_r;
  assign bus.tx_done = tx_done_r;
  assign bus.tx_rdy  = ~hold_vld_r;
  assign bus.busy    = (state_r != IDLE);

endmodule
